// File: rtl/countdown_timer.sv
// Loadable seconds down-counter with internal 1 s prescaler; optional periodic mode via COUNTDOWN_AUTO_RELOAD_EN.
// Latency: seconds_left valid one edge after start; expiry N*TICK_MAX edges after start.
// Backpressure: none; pause level freezes the count, abort pulse cancels at any time.
module countdown_timer #(
    parameter int TICK_MAX = 25_000_000,
    parameter int SEC_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEC_W-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [SEC_W-1:0] seconds_left,
    output logic             busy,
    output logic             expired
);

    localparam int              PRE_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_MAX - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_nxt;
    logic [SEC_W-1:0] seconds_nxt;
    logic             expired_nxt;
    logic             start_ok;
    logic             tick;

    // A zero load would expire immediately, so it is treated as no request.
    assign start_ok = start && (load_val != '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [SEC_W-1:0] reload_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_val <= '0;
        end else if (!abort && start_ok) begin
            reload_val <= load_val;
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        seconds_nxt   = seconds_left;
        expired_nxt   = 1'b0;
        tick          = 1'b0;

        if (abort) begin
            state_nxt     = IDLE;
            prescaler_nxt = '0;
            seconds_nxt   = '0;
        end else if (start_ok) begin
            state_nxt     = pause ? PAUSED : RUN;
            prescaler_nxt = '0;
            seconds_nxt   = load_val;
        end else begin
            case (state)
                RUN, PAUSED: begin
                    // Leaving PAUSED advances the prescaler on the same edge,
                    // so the partial second resumes without a dead cycle.
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else begin
                        state_nxt = RUN;
                        if (prescaler == PRE_LAST) begin
                            prescaler_nxt = '0;
                            tick          = 1'b1;
                        end else begin
                            prescaler_nxt = prescaler + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase

            if (tick) begin
                if (seconds_left <= SEC_ONE) begin
                    expired_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    seconds_nxt = reload_val;
                    state_nxt   = RUN;
`else
                    seconds_nxt = '0;
                    state_nxt   = DONE;
`endif
                end else begin
                    seconds_nxt = seconds_left - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= '0;
            expired      <= 1'b0;
        end else begin
            state        <= state_nxt;
            prescaler    <= prescaler_nxt;
            seconds_left <= seconds_nxt;
            expired      <= expired_nxt;
        end
    end

    assign busy = (state == RUN) || (state == PAUSED);

endmodule
